// File: rtl/gshare_predictor.sv
// Fetch-stage gshare direction predictor with a direct-mapped BTB.
// Lookup is combinational; training and history repair come from the EX resolution bundle.
module gshare_predictor #(
  parameter int unsigned GSHARE_GHSR_WIDTH = 8,
  parameter int unsigned BTB_ENTRIES       = 64
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         fetch_valid,
  input  logic [31:0]                  fetch_pc,
  output logic                         pred_taken,
  output logic [31:0]                  pred_target,
  output logic [GSHARE_GHSR_WIDTH-1:0] pred_ghsr,
  input  logic                         io_branch_valid,
  input  logic                         io_branch_taken,
  input  logic [31:0]                  io_branch_instr_pc,
  input  logic [31:0]                  io_branch_target_addr,
  input  logic                         io_branch_is_mispred,
  input  logic [GSHARE_GHSR_WIDTH-1:0] io_GHSR_restore
);

  localparam int unsigned W           = GSHARE_GHSR_WIDTH;
  localparam int unsigned PHT_ENTRIES = 1 << W;
  localparam int unsigned BTB_IDX     = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_W       = 31 - BTB_IDX;

  logic [W-1:0]       ghsr;
  logic [1:0]         pht        [PHT_ENTRIES];
  logic               btb_valid  [BTB_ENTRIES];
  logic [TAG_W-1:0]   btb_tag    [BTB_ENTRIES];
  logic [31:0]        btb_target [BTB_ENTRIES];

  logic [W-1:0]       fetch_pht_idx;
  logic [BTB_IDX-1:0] fetch_btb_idx;
  logic [TAG_W-1:0]   fetch_tag;
  logic               btb_hit;
  logic [W-1:0]       train_pht_idx;
  logic [BTB_IDX-1:0] train_btb_idx;
  logic [TAG_W-1:0]   train_tag;
  logic               repair;

  // Lookup: sees pre-write state, no bypass from same-cycle training
  always_comb begin
    fetch_pht_idx = fetch_pc[W:1] ^ ghsr;
    fetch_btb_idx = fetch_pc[BTB_IDX:1];
    fetch_tag     = fetch_pc[31:BTB_IDX+1];
    btb_hit       = btb_valid[fetch_btb_idx] && (btb_tag[fetch_btb_idx] == fetch_tag);
    pred_taken    = btb_hit && pht[fetch_pht_idx][1];
    pred_target   = btb_hit ? btb_target[fetch_btb_idx] : 32'd0;
    pred_ghsr     = ghsr;
  end

  always_comb begin
    train_pht_idx = io_branch_instr_pc[W:1] ^ io_GHSR_restore;
    train_btb_idx = io_branch_instr_pc[BTB_IDX:1];
    train_tag     = io_branch_instr_pc[31:BTB_IDX+1];
    repair        = io_branch_valid && io_branch_is_mispred;
  end

  // Global history: repair from the resolved snapshot beats the speculative shift
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ghsr <= '0;
    end else if (repair) begin
      ghsr <= {io_GHSR_restore[W-2:0], io_branch_taken};
    end else if (fetch_valid && btb_hit) begin
      ghsr <= {ghsr[W-2:0], pred_taken};
    end
  end

  // Saturating 2-bit counters, reset to weakly not-taken
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(PHT_ENTRIES); i++) pht[i] <= 2'b01;
    end else if (io_branch_valid) begin
      if (io_branch_taken && (pht[train_pht_idx] != 2'b11))
        pht[train_pht_idx] <= pht[train_pht_idx] + 2'd1;
      else if (!io_branch_taken && (pht[train_pht_idx] != 2'b00))
        pht[train_pht_idx] <= pht[train_pht_idx] - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(BTB_ENTRIES); i++) btb_valid[i] <= 1'b0;
    end else if (io_branch_valid && io_branch_taken) begin
      btb_valid[train_btb_idx] <= 1'b1;
    end
  end

  // Tag/target storage needs no reset; valid bits gate their use
  always_ff @(posedge clk) begin
    if (io_branch_valid && io_branch_taken) begin
      btb_tag[train_btb_idx]    <= train_tag;
      btb_target[train_btb_idx] <= io_branch_target_addr;
    end
  end

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench for gshare_predictor: reset, training, saturation, history shift/repair, BTB conflict.
module tb_gshare_predictor;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         fetch_valid;
  logic [31:0]  fetch_pc;
  logic         pred_taken;
  logic [31:0]  pred_target;
  logic [W-1:0] pred_ghsr;
  logic         io_branch_valid;
  logic         io_branch_taken;
  logic [31:0]  io_branch_instr_pc;
  logic [31:0]  io_branch_target_addr;
  logic         io_branch_is_mispred;
  logic [W-1:0] io_GHSR_restore;

  int checks = 0;
  int passed = 0;

  gshare_predictor #(.GSHARE_GHSR_WIDTH(W), .BTB_ENTRIES(64)) dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .fetch_valid           (fetch_valid),
    .fetch_pc              (fetch_pc),
    .pred_taken            (pred_taken),
    .pred_target           (pred_target),
    .pred_ghsr             (pred_ghsr),
    .io_branch_valid       (io_branch_valid),
    .io_branch_taken       (io_branch_taken),
    .io_branch_instr_pc    (io_branch_instr_pc),
    .io_branch_target_addr (io_branch_target_addr),
    .io_branch_is_mispred  (io_branch_is_mispred),
    .io_GHSR_restore       (io_GHSR_restore)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic clear_br();
    io_branch_valid       = 1'b0;
    io_branch_taken       = 1'b0;
    io_branch_instr_pc    = 32'd0;
    io_branch_target_addr = 32'd0;
    io_branch_is_mispred  = 1'b0;
    io_GHSR_restore       = '0;
  endtask

  // Advance one edge; inputs are changed 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                         input logic mispred, input logic [W-1:0] restore);
    io_branch_valid       = 1'b1;
    io_branch_taken       = taken;
    io_branch_instr_pc    = pc;
    io_branch_target_addr = tgt;
    io_branch_is_mispred  = mispred;
    io_GHSR_restore       = restore;
    tick();
    clear_br();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic fetch_check(input string tag, input logic [31:0] pc, input logic exp_taken);
    fetch_pc = pc;
    #1;
    chk(tag, 32'(pred_taken), 32'(exp_taken));
  endtask

  initial begin
    reset_n     = 1'b0;
    fetch_valid = 1'b0;
    fetch_pc    = 32'd0;
    clear_br();
    #12;
    reset_n = 1'b1;
    tick();

    // Loop training from clean state
    resolve(32'h80, 1'b1, 32'h40, 1'b1, 8'h00);
    #1;
    chk("t2_ghsr", 32'(pred_ghsr), 32'h01);
    fetch_check("t2_idx41_not_taken", 32'h80, 1'b0);

    // Asynchronous reset mid-run, checked before any clock edge
    tick();
    fetch_pc = 32'h80;
    reset_n  = 1'b0;
    #1;
    chk("t1_rst_ghsr", 32'(pred_ghsr), 32'h00);
    chk("t1_rst_taken", 32'(pred_taken), 32'h0);
    #1;
    reset_n = 1'b1;
    tick();
    resolve(32'h100, 1'b1, 32'h200, 1'b0, 8'h00);
    fetch_check("t1_counter_10_taken", 32'h100, 1'b1);
    chk("t1_target", pred_target, 32'h200);

    // Saturation at index 0x80: fresh counter 01
    do_reset();
    resolve(32'h100, 1'b1, 32'h200, 1'b0, 8'h00);
    fetch_check("t3_T1_c2", 32'h100, 1'b1);
    resolve(32'h100, 1'b1, 32'h200, 1'b0, 8'h00);
    fetch_check("t3_T2_c3", 32'h100, 1'b1);
    resolve(32'h100, 1'b1, 32'h200, 1'b0, 8'h00);
    resolve(32'h100, 1'b1, 32'h200, 1'b0, 8'h00);
    fetch_check("t3_T4_c3", 32'h100, 1'b1);
    resolve(32'h100, 1'b0, 32'h0, 1'b0, 8'h00);
    fetch_check("t3_N1_c2", 32'h100, 1'b1);
    resolve(32'h100, 1'b0, 32'h0, 1'b0, 8'h00);
    fetch_check("t3_N2_c1", 32'h100, 1'b0);
    resolve(32'h100, 1'b0, 32'h0, 1'b0, 8'h00);
    resolve(32'h100, 1'b0, 32'h0, 1'b0, 8'h00);
    resolve(32'h100, 1'b0, 32'h0, 1'b0, 8'h00);
    fetch_check("t3_N5_c0", 32'h100, 1'b0);
    resolve(32'h100, 1'b1, 32'h200, 1'b0, 8'h00);
    fetch_check("t3_T_after_floor_c1", 32'h100, 1'b0);
    resolve(32'h100, 1'b1, 32'h200, 1'b0, 8'h00);
    fetch_check("t3_T_after_floor_c2", 32'h100, 1'b1);

    // Speculative shift vs stall: PHT[0x80^0x5A]=2, then repair ghsr to 0x5A
    do_reset();
    resolve(32'h100, 1'b1, 32'h300, 1'b0, 8'h5A);
    resolve(32'h200, 1'b0, 32'h0, 1'b1, 8'h2D);
    fetch_check("t4_hit_taken", 32'h100, 1'b1);
    chk("t4_ghsr_5a", 32'(pred_ghsr), 32'h5A);
    tick();
    chk("t4_stall_keeps", 32'(pred_ghsr), 32'h5A);
    fetch_valid = 1'b1;
    tick();
    fetch_valid = 1'b0;
    chk("t4_shift_b5", 32'(pred_ghsr), 32'hB5);

    // Repair wins over a same-cycle speculative shift
    fetch_pc    = 32'h100;
    fetch_valid = 1'b1;
    resolve(32'h200, 1'b0, 32'h0, 1'b1, 8'h33);
    fetch_valid = 1'b0;
    chk("t5_repair_66", 32'(pred_ghsr), 32'h66);
    io_branch_is_mispred = 1'b1;
    io_GHSR_restore      = 8'hFF;
    tick();
    clear_br();
    chk("t5_mispred_no_valid", 32'(pred_ghsr), 32'h66);

    // BTB alias: 0x10 and 0x90 share index 8 with different tags
    do_reset();
    resolve(32'h10, 1'b1, 32'h1000, 1'b0, 8'h00);
    fetch_check("t6_hit_0x10", 32'h10, 1'b1);
    chk("t6_target_0x10", pred_target, 32'h1000);
    resolve(32'h90, 1'b1, 32'h2000, 1'b0, 8'h00);
    fetch_check("t6_0x10_evicted", 32'h10, 1'b0);
    fetch_check("t6_hit_0x90", 32'h90, 1'b1);
    resolve(32'h90, 1'b0, 32'h0, 1'b0, 8'h01);
    fetch_check("t6_nt_keeps_valid", 32'h90, 1'b1);
    chk("t6_target_0x90", pred_target, 32'h2000);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/gshare_predictor.md
# gshare_predictor

Fetch-stage branch predictor combining a global-history (gshare) pattern history table with a direct-mapped branch target buffer. It sits inside the IF stage. Each cycle it returns a taken/target prediction for the current fetch PC. It also consumes the branch-resolution bundle driven by EX (valid, taken, PC, target, mispredict, GHSR restore) to train its tables and repair the speculative global history.

## Interface
Parameters:
- GSHARE_GHSR_WIDTH, 8, global history length; the PHT has 2^GSHARE_GHSR_WIDTH 2-bit counters. Taken from `common`.
- BTB_ENTRIES, 64, BTB depth; must be a power of two; BTB_IDX = log2(BTB_ENTRIES).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- fetch_valid  in  1  a fetch is issued this cycle (IF not stalled).
- fetch_pc  in  32  PC being fetched; halfword aligned (compressed ISA).
- pred_taken  out  1  predict taken: BTB hit and PHT counter MSB = 1.
- pred_target  out  32  BTB target; valid only when pred_taken = 1.
- pred_ghsr  out  GSHARE_GHSR_WIDTH  GHSR before this fetch's shift; IF pipelines it down to EX for restore.
- io_branch_valid  in  1  EX resolved a branch or jump this cycle.
- io_branch_taken  in  1  actual direction.
- io_branch_instr_pc  in  32  PC of the resolved instruction.
- io_branch_target_addr  in  32  actual taken target.
- io_branch_is_mispred  in  1  direction or target mispredicted, including a BTB miss on a taken branch.
- io_GHSR_restore  in  GSHARE_GHSR_WIDTH  pred_ghsr snapshot carried with the resolved instruction.

## Operation
- PHT index = fetch_pc[GSHARE_GHSR_WIDTH:1] XOR ghsr. Training index = io_branch_instr_pc[GSHARE_GHSR_WIDTH:1] XOR io_GHSR_restore.
- BTB index = pc[BTB_IDX:1]. Tag = pc[31:BTB_IDX+1]. Each entry holds a valid bit, the tag and a 32-bit target. Hit requires valid = 1 and a tag match.
- Lookup is purely combinational from fetch_pc and the current state. pred_ghsr = ghsr.
- Speculative history:
  - When fetch_valid and BTB hit, ghsr <= {ghsr[W-2:0], pred_taken} on the next edge.
  - When there is no BTB hit, ghsr is unchanged.
- Repair: when io_branch_valid and io_branch_is_mispred, ghsr <= {io_GHSR_restore[W-2:0], io_branch_taken}.
  - Repair overrides any speculative shift in the same cycle.
- PHT training: on every io_branch_valid, the indexed 2-bit counter is updated.
  - Taken: increment, saturating at 3.
  - Not taken: decrement, saturating at 0.
- BTB training:
  - When io_branch_valid and io_branch_taken, write valid = 1, the tag and io_branch_target_addr into the indexed entry. This replaces any prior occupant.
  - Not-taken resolutions never allocate and never invalidate.
- No bypass: a lookup in the same cycle as a training write to the same entry sees the pre-write contents.

## Timing
- Reset (reset_n = 0, asynchronous, any time including mid-operation):
  - ghsr = 0.
  - All BTB valid bits = 0.
  - All PHT counters = 2'b01 (weakly not-taken).
  - Resulting outputs: pred_taken = 0, pred_target = don't-care (drive 0), pred_ghsr = 0.
- Prediction latency is 0 cycles (combinational from fetch_pc).
- Training and repair take effect on the edge after io_branch_valid is sampled. They are visible to a lookup in the following cycle.
- A mispredict arrives with io_branch_valid = 1 in the same cycle. io_branch_is_mispred with io_branch_valid = 0 is ignored.
- At most one resolution per cycle; one fetch lookup per cycle.
- History shift happens only when fetch_valid = 1. A stalled fetch (fetch_valid = 0) must leave ghsr untouched even on a BTB hit.

## Test plan
1. Reset defaults:
   - Stimulus: assert reset_n = 0 mid-run after training; release; fetch any PC.
   - Required: pred_taken = 0, pred_ghsr = 0.
   - Then resolve a taken branch at 0x100 and fetch 0x100 again. Required: counter 01→10, so pred_taken = 1.
2. Loop training:
   - Stimulus: resolve taken branch PC = 0x80, target 0x40, mispred = 1, restore = 0.
   - Required next cycle: ghsr = 0x01; BTB hit at 0x80 with pred_target = 0x40. PHT[0x40^0x00] = 2'b10.
   - Then fetch 0x80 with ghsr = 0x01, index 0x41: counter = 01, so pred_taken = 0.
3. Saturation:
   - Stimulus: four taken resolutions to the same index, then five not-taken.
   - Required: counter holds 3 after the third taken and 0 after the fourth not-taken; no wrap.
4. Speculative shift versus stall:
   - Stimulus: BTB hit with pred_taken = 1 at ghsr = 0x5A and fetch_valid = 1.
   - Required: ghsr = 0xB5 next cycle. The same lookup with fetch_valid = 0 leaves ghsr at 0x5A.
5. Simultaneous repair and fetch:
   - Stimulus: fetch_valid = 1 on a BTB hit while a mispredict resolves with restore = 0x33, taken = 0.
   - Required: ghsr = 0x66, not the speculative value.
6. BTB alias and conflict:
   - Stimulus: taken branches at PCs 0x0000_0010 and 0x0000_0090 with BTB_ENTRIES = 64 (same index, different tag).
   - Required: the second replaces the first; fetching 0x10 misses (pred_taken = 0).
   - A not-taken resolution at 0x90 keeps the entry valid.
